bus_cmd_queue: RTL and testbench

BUS_CMD_QUEUE -- requirements
Module: bus_cmd_queue

---
 rtl/bus_cmd_queue.sv | 225 ++++++++++++++++++++++
 tb/tb_bus_cmd_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cmd_queue.sv
// bus_cmd_queue: queues host bus commands in a small FIFO and runs them one
// at a time on a downstream bus (IDLE -> ISSUE -> WAIT -> RSP), then returns
// a response. Addresses 0xF0-0xFF are reserved: they are still issued, but
// they return an error with zero data.
// Optional build macro BUS_CMD_TIMEOUT_EN adds a WAIT-cycle counter. The
// counter aborts a bus access after TIMEOUT cycles without bus_ready.
module bus_cmd_queue #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_write,
   input  logic [7:0]                 cmd_addr,
   input  logic [31:0]                cmd_wdata,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [31:0]                rsp_rdata,
   output logic                       rsp_write,
   output logic                       rsp_err,
   output logic                       bus_valid,
   output logic                       bus_write,
   output logic [7:0]                 bus_addr,
   output logic [31:0]                bus_wdata,
   input  logic [31:0]                bus_rdata,
   input  logic                       bus_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RSP   = 2'd3
   } state_t;

   state_t          state_r, state_s;
   logic [7:0]      fifo_addr_r  [DEPTH];
   logic [31:0]     fifo_wdata_r [DEPTH];
   logic            fifo_write_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
   logic [LW-1:0]   level_r, level_s;
   logic            push_s, pop_s, cap_s, tmo_s;
   logic            cmd_ready_r, busy_r;
   logic            bus_valid_r, bus_write_r;
   logic [7:0]      bus_addr_r;
   logic [31:0]     bus_wdata_r;
   logic            rsp_valid_r, rsp_write_r, rsp_err_r;
   logic [31:0]     rsp_rdata_r;

   // Upper address nibble 0xF marks the reserved error space.
   function automatic logic is_reserved(input logic [7:0] addr);
      return (addr[7:4] == 4'hF);
   endfunction

   assign push_s = cmd_valid && cmd_ready_r;

`ifdef BUS_CMD_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
   logic [CW-1:0] wait_cnt_r;

   // Count WAIT cycles; cleared on every entry into WAIT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt_r <= {CW{1'b0}};
      end else if (state_r == WAIT) begin
         wait_cnt_r <= wait_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         wait_cnt_r <= {CW{1'b0}};
      end
   end
`endif

   // Next-state logic plus the pop, capture and timeout strobes.
   always_comb begin
      state_s = state_r;
      pop_s   = 1'b0;
      cap_s   = 1'b0;
      tmo_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (level_r != {LW{1'b0}}) begin
               state_s = ISSUE;
               pop_s   = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            state_s = WAIT;
         end
         WAIT: begin
            if (bus_ready) begin
               state_s = RSP;
               cap_s   = 1'b1;
            end
`ifdef BUS_CMD_TIMEOUT_EN
            else if (wait_cnt_r == TMO_LAST) begin
               state_s = RSP;
               tmo_s   = 1'b1;
            end
`endif
            else begin
               state_s = WAIT;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               if (level_r != {LW{1'b0}}) begin
                  state_s = ISSUE;
                  pop_s   = 1'b1;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               state_s = RSP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Occupancy after this edge; a push and a pop together cancel out.
   always_comb begin
      level_s = level_r;
      case ({push_s, pop_s})
         2'b10:   level_s = level_r + {{(LW-1){1'b0}}, 1'b1};
         2'b01:   level_s = level_r - {{(LW-1){1'b0}}, 1'b1};
         default: level_s = level_r;
      endcase
   end

   // FIFO storage; it needs no reset because the pointers and level define its contents.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_addr_r[wr_ptr_r]  <= cmd_addr;
         fifo_wdata_r[wr_ptr_r] <= cmd_wdata;
         fifo_write_r[wr_ptr_r] <= cmd_write;
      end
   end

   // State, pointers, level, and registered status flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         wr_ptr_r    <= {AW{1'b0}};
         rd_ptr_r    <= {AW{1'b0}};
         level_r     <= {LW{1'b0}};
         cmd_ready_r <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         level_r     <= level_s;
         cmd_ready_r <= (level_s != FULL_LVL);
         busy_r      <= (state_s != IDLE) || (level_s != {LW{1'b0}});
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
      end
   end

   // Bus request fields: loaded on pop and held from ISSUE through RSP.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus_valid_r <= 1'b0;
         bus_write_r <= 1'b0;
         bus_addr_r  <= 8'h00;
         bus_wdata_r <= 32'h0000_0000;
      end else begin
         bus_valid_r <= (state_s == ISSUE);
         if (pop_s) begin
            bus_addr_r  <= fifo_addr_r[rd_ptr_r];
            bus_wdata_r <= fifo_wdata_r[rd_ptr_r];
            bus_write_r <= fifo_write_r[rd_ptr_r];
         end
      end
   end

   // Response fields: captured when WAIT ends and held stable through RSP.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 32'h0000_0000;
         rsp_write_r <= 1'b0;
         rsp_err_r   <= 1'b0;
      end else begin
         rsp_valid_r <= (state_s == RSP);
         if (cap_s) begin
            rsp_rdata_r <= (bus_write_r || is_reserved(bus_addr_r)) ? 32'h0000_0000 : bus_rdata;
            rsp_err_r   <= is_reserved(bus_addr_r);
            rsp_write_r <= bus_write_r;
         end else if (tmo_s) begin
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b1;
            rsp_write_r <= bus_write_r;
         end
      end
   end

   assign cmd_ready = cmd_ready_r;
   assign level     = level_r;
   assign busy      = busy_r;
   assign bus_valid = bus_valid_r;
   assign bus_write = bus_write_r;
   assign bus_addr  = bus_addr_r;
   assign bus_wdata = bus_wdata_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_write = rsp_write_r;
   assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_bus_cmd_queue.sv
// Directed self-checking bench for bus_cmd_queue (DEPTH=4, TIMEOUT=16).
// The downstream bus is a tiny model: it remembers the last write. A read of
// that same address returns the written data. Any other read returns
// {24'hA5A5A5, addr}.
module tb_bus_cmd_queue;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [7:0]  cmd_addr = 8'h00;
   logic [31:0] cmd_wdata = 32'h0;
   logic        rsp_ready = 1'b0, bus_ready = 1'b1;
   logic        cmd_ready, rsp_valid, rsp_write, rsp_err, bus_valid, bus_write, busy;
   logic [31:0] rsp_rdata, bus_wdata, bus_rdata;
   logic [7:0]  bus_addr;
   logic [2:0]  level;

   int vec_cnt = 0;
   int miscmp_cnt = 0;
   int bv_high = 0, bv_pulses = 0;
   logic bv_prev = 1'b0;
   logic [7:0] last_bus_addr = 8'h00;

   logic        bm_vld;
   logic [7:0]  bm_addr;
   logic [31:0] bm_data;

   bus_cmd_queue #(.DEPTH(4), .TIMEOUT(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_write(rsp_write), .rsp_err(rsp_err),
      .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
      .level(level), .busy(busy)
   );

   always #5 clk = ~clk;

   // Downstream bus model: remember the last write.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bm_vld  <= 1'b0;
         bm_addr <= 8'h00;
         bm_data <= 32'h0;
      end else if (bus_valid && bus_write) begin
         bm_vld  <= 1'b1;
         bm_addr <= bus_addr;
         bm_data <= bus_wdata;
      end
   end
   assign bus_rdata = (bm_vld && bm_addr == bus_addr) ? bm_data : {24'hA5A5A5, bus_addr};

   // Count bus_valid pulses and high cycles so the bench can check that every pulse is one cycle wide.
   always @(negedge clk) begin
      if (bus_valid) begin
         bv_high = bv_high + 1;
         if (!bv_prev) bv_pulses = bv_pulses + 1;
         last_bus_addr = bus_addr;
      end
      bv_prev = bus_valid;
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miscmp_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after acceptance.
   task automatic push(input logic w, input logic [7:0] a, input logic [31:0] d);
      int n = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      while (!cmd_ready && n < 60) begin @(negedge clk); n++; end
      if (n >= 60) check_vec("push_timeout", 32'(n), 32'd0);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic collect_rsp(input string tag, input logic ew, input logic ee, input logic [31:0] ed);
      int n = 0;
      while (!rsp_valid && n < 60) begin @(negedge clk); n++; end
      check_vec({tag, "_seen"}, rsp_valid, 1'b1);
      check_vec({tag, "_write"}, rsp_write, ew);
      check_vec({tag, "_err"}, rsp_err, ee);
      check_vec({tag, "_rdata"}, rsp_rdata, ed);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      int seen;
      // ---- reset state ----
      repeat (3) @(negedge clk);
      check_vec("rst_cmd_ready", cmd_ready, 1'b1);
      check_vec("rst_level", level, 3'd0);
      check_vec("rst_busy", busy, 1'b0);
      check_vec("rst_bus_valid", bus_valid, 1'b0);
      check_vec("rst_bus_addr", bus_addr, 8'h00);
      check_vec("rst_bus_wdata", bus_wdata, 32'h0);
      check_vec("rst_bus_write", bus_write, 1'b0);
      check_vec("rst_rsp_valid", rsp_valid, 1'b0);
      check_vec("rst_rsp_rdata", rsp_rdata, 32'h0);
      check_vec("rst_rsp_err", rsp_err, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);

      // ---- write 0x10 then read 0x10, latency and held response ----
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'hDEADBEEF;
      @(negedge clk);
      cmd_valid = 1'b0;
      check_vec("lat_level1", level, 3'd1);
      check_vec("lat_bv_idle", bus_valid, 1'b0);
      check_vec("lat_busy", busy, 1'b1);
      @(negedge clk);
      check_vec("issue_bv", bus_valid, 1'b1);
      check_vec("issue_addr", bus_addr, 8'h10);
      check_vec("issue_wdata", bus_wdata, 32'hDEADBEEF);
      check_vec("issue_write", bus_write, 1'b1);
      check_vec("issue_level0", level, 3'd0);
      @(negedge clk);
      check_vec("wait_bv", bus_valid, 1'b0);
      check_vec("wait_rsp_valid", rsp_valid, 1'b0);
      @(negedge clk);
      check_vec("wr_rsp_valid", rsp_valid, 1'b1);
      check_vec("wr_rsp_write", rsp_write, 1'b1);
      check_vec("wr_rsp_err", rsp_err, 1'b0);
      check_vec("wr_rsp_rdata", rsp_rdata, 32'h0);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; cmd_wdata = 32'h0;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_vec("hold_rsp_valid", rsp_valid, 1'b1);
         check_vec("hold_rsp_rdata", rsp_rdata, 32'h0);
         check_vec("hold_rsp_write", rsp_write, 1'b1);
         check_vec("hold_no_bv", bus_valid, 1'b0);
         check_vec("hold_bus_addr", bus_addr, 8'h10);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_vec("b2b_rsp_drop", rsp_valid, 1'b0);
      check_vec("b2b_bv", bus_valid, 1'b1);
      check_vec("b2b_bus_write", bus_write, 1'b0);
      collect_rsp("rd10", 1'b0, 1'b0, 32'hDEADBEEF);
      check_vec("rd10_idle_busy", busy, 1'b0);

      // ---- fill: DEPTH+1 commands while the first is stuck in RSP ----
      for (int i = 0; i < 5; i++) push(1'b0, 8'(8'h20 + i), 32'h0);
      check_vec("full_level", level, 3'd4);
      check_vec("full_cmd_ready", cmd_ready, 1'b0);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h25; cmd_wdata = 32'h0;
      @(negedge clk);
      check_vec("full_still_level", level, 3'd4);
      check_vec("full_pop_no_ready", cmd_ready, 1'b0);
      collect_rsp("q0", 1'b0, 1'b0, 32'hA5A5A520);
      check_vec("after_pop_level", level, 3'd3);
      check_vec("after_pop_ready", cmd_ready, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_vec("refill_level", level, 3'd4);
      for (int i = 1; i < 6; i++) collect_rsp("qn", 1'b0, 1'b0, 32'hA5A5A520 + 32'(i));

      // ---- reserved space: read 0xF3 and write 0xF0 ----
      push(1'b0, 8'hF3, 32'h0);
      collect_rsp("res_rd", 1'b0, 1'b1, 32'h0);
      check_vec("res_rd_issued", last_bus_addr, 8'hF3);
      push(1'b1, 8'hF0, 32'h12345678);
      collect_rsp("res_wr", 1'b1, 1'b1, 32'h0);

      // ---- bus_ready held low ----
      bus_ready = 1'b0;
      push(1'b0, 8'h30, 32'h0);
`ifdef BUS_CMD_TIMEOUT_EN
      begin
         int n = 0;
         while (!bus_valid && n < 20) begin @(negedge clk); n++; end
         n = 0;
         while (!rsp_valid && n < 60) begin @(negedge clk); n++; end
         check_vec("tmo_cycles", 32'(n), 32'd17);
         collect_rsp("tmo", 1'b0, 1'b1, 32'h0);
      end
`else
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      check_vec("no_tmo_rsp", 32'(seen), 32'd0);
      check_vec("no_tmo_busy", busy, 1'b1);
      bus_ready = 1'b1;
      collect_rsp("late", 1'b0, 1'b0, 32'hA5A5A530);
      bus_ready = 1'b0;
`endif

      // ---- reset during WAIT with two queued commands ----
      push(1'b0, 8'h40, 32'h0);
      push(1'b0, 8'h41, 32'h0);
      push(1'b0, 8'h42, 32'h0);
      check_vec("pre_rst_level", level, 3'd2);
      check_vec("pre_rst_busy", busy, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check_vec("arst_level", level, 3'd0);
      check_vec("arst_bv", bus_valid, 1'b0);
      check_vec("arst_rsp_valid", rsp_valid, 1'b0);
      check_vec("arst_busy", busy, 1'b0);
      check_vec("arst_cmd_ready", cmd_ready, 1'b1);
      @(negedge clk);
      check_vec("rst_next_level", level, 3'd0);
      reset_n = 1'b1;
      bus_ready = 1'b1;
      rsp_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid || bus_valid) seen++;
      end
      check_vec("post_rst_quiet", 32'(seen), 32'd0);

      // ---- bus_valid pulse accounting ----
      check_vec("bv_pulse_count", 32'(bv_pulses), 32'd12);
      check_vec("bv_one_wide", 32'(bv_high), 32'(bv_pulses));

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
      $finish;
   end

endmodule
